// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one line-wide physical memory port between the icache
// (line fills) and the dcache (line fills and writebacks). One transaction is
// in flight at a time. The winner gets a one-cycle resp pulse, and grants
// alternate between the two caches under contention.
module pmem_arbiter #(
    parameter int unsigned s_addr = 32,
    parameter int unsigned s_line = 256
) (
    input  logic              clk,
    input  logic              rst,

    // icache miss path
    input  logic [s_addr-1:0] i_pmem_address,
    input  logic              i_pmem_read,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    // dcache miss path
    input  logic [s_addr-1:0] d_pmem_address,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    // memory / L2 side
    output logic [s_addr-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [s_line-1:0] mem_wdata,
    input  logic [s_line-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [2:0] {
        StIdle,
        StGrantI,
        StGrantD,
        StRespI,
        StRespD
    } state_e;

    state_e            state_q;
    logic              last_d_q;   // 1 when the dcache won the most recent grant
    logic              write_q;    // latched op of the granted transaction
    logic [s_addr-1:0] addr_q;
    logic [s_line-1:0] wdata_q;
    logic [s_line-1:0] line_q;     // last line captured from memory

    logic req_i;
    logic req_d;
    logic pick_d;

    // The memory side and both return paths are driven only from latched state.
    assign mem_address  = addr_q;
    assign mem_wdata    = wdata_q;
    assign i_pmem_rdata = line_q;
    assign d_pmem_rdata = line_q;

    // Request decode and arbitration pick: under contention, serve whoever did not go last.
    always_comb begin
        req_i  = i_pmem_read;
        req_d  = d_pmem_read | d_pmem_write;
        pick_d = req_d & (~req_i | ~last_d_q);
    end

    // Transaction sequencer: latch the winner, hold its strobe until mem_resp, then pulse resp.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            last_d_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            line_q      <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            i_pmem_resp <= 1'b0;
            d_pmem_resp <= 1'b0;
        end else begin
            i_pmem_resp <= 1'b0;
            d_pmem_resp <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_i || req_d) begin
                        if (pick_d) begin
                            state_q   <= StGrantD;
                            last_d_q  <= 1'b1;
                            addr_q    <= d_pmem_address;
                            wdata_q   <= d_pmem_wdata;
                            // A simultaneous read+write is treated as a writeback.
                            write_q   <= d_pmem_write;
                            mem_read  <= ~d_pmem_write;
                            mem_write <= d_pmem_write;
                        end else begin
                            state_q   <= StGrantI;
                            last_d_q  <= 1'b0;
                            addr_q    <= i_pmem_address;
                            write_q   <= 1'b0;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                        end
                    end
                end
                StGrantI, StGrantD: begin
                    if (mem_resp) begin
                        if (!write_q) begin
                            line_q <= mem_rdata;
                        end
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        i_pmem_resp <= (state_q == StGrantI);
                        d_pmem_resp <= (state_q == StGrantD);
                        state_q     <= (state_q == StGrantI) ? StRespI : StRespD;
                    end
                end
                // Resp cycle: no new grant, which forces an idle turnaround.
                StRespI, StRespD: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // The dcache must never request a fill and a writeback together.
    a_d_read_write_exclusive: assert property (
        @(posedge clk) disable iff (!rst) !(d_pmem_read && d_pmem_write)
    );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios, a transaction-level reference
// model checked every cycle, and literal expectations for each scenario.
module tb_pmem_arbiter;

    localparam logic [255:0] LINE_A = {8{32'hA5A5_4A5A}};   // line_for(0x1000)
    localparam logic [255:0] LINE_B = {8{32'hB0B0_0001}};
    localparam logic [255:0] LINE_C = {8{32'hC0C0_0002}};
    localparam logic [255:0] LINE_D = {8{32'hD0D0_0003}};

    logic         clk;
    logic         rst;
    logic [31:0]  i_pmem_address;
    logic         i_pmem_read;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic [31:0]  d_pmem_address;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    pmem_arbiter #(.s_addr(32), .s_line(256)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_address (i_pmem_address),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_address (d_pmem_address),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] line_for(input logic [31:0] a);
        return {8{a ^ 32'hA5A5_5A5A}};
    endfunction

    // ---------------- memory responder ----------------
    int mem_lat = 4;
    bit stray = 1'b0;
    initial begin
        int cnt;
        cnt = 0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) cnt++;
            else cnt = 0;
            if (stray) begin
                mem_resp = 1'b1;
                mem_rdata = {8{32'hDEAD_BEEF}};
            end else if ((mem_read || mem_write) && cnt == mem_lat) begin
                mem_resp = 1'b1;
                mem_rdata = line_for(mem_address);
            end else begin
                mem_resp = 1'b0;
            end
        end
    end

    // ---------------- requester agents ----------------
    // Drop the request in the cycle after resp, stay low one cycle, then re-request if more left.
    int i_left = 0;
    int d_left = 0;
    logic [31:0] i_next = 32'h0;
    logic [31:0] d_next = 32'h0;
    initial begin
        bit cool;
        cool = 1'b0;
        forever begin
            @(negedge clk);
            if (i_pmem_resp) begin
                i_pmem_read = 1'b0;
                cool = 1'b1;
            end else if (cool) begin
                cool = 1'b0;
            end else if (!i_pmem_read && i_left > 0) begin
                i_pmem_read = 1'b1;
                i_pmem_address = i_next;
                i_next += 32'h40;
                i_left--;
            end
        end
    end
    initial begin
        bit cool;
        cool = 1'b0;
        forever begin
            @(negedge clk);
            if (d_pmem_resp) begin
                d_pmem_read = 1'b0;
                d_pmem_write = 1'b0;
                cool = 1'b1;
            end else if (cool) begin
                cool = 1'b0;
            end else if (!d_pmem_read && !d_pmem_write && d_left > 0) begin
                d_pmem_read = 1'b1;
                d_pmem_address = d_next;
                d_next += 32'h40;
                d_left--;
            end
        end
    end

    // ---------------- reference model ----------------
    // Transaction view: at most one open transaction; after it completes, one resp
    // cycle goes to its owner during which nothing new is accepted.
    bit           m_busy = 1'b0;
    int           m_who = 0;        // 1 = icache, 2 = dcache
    bit           m_wr = 1'b0;
    logic [31:0]  m_addr = '0;
    logic [255:0] m_wdata = '0;
    logic [255:0] m_line = '0;
    int           m_last = 1;
    int           m_resp_to = 0;

    task automatic model_step();
        bit want_i;
        bit want_d;
        int who;
        if (!rst) begin
            m_busy = 1'b0; m_who = 0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
            m_line = '0; m_last = 1; m_resp_to = 0;
        end else if (m_resp_to != 0) begin
            m_resp_to = 0;
        end else if (m_busy) begin
            if (mem_resp) begin
                if (!m_wr) m_line = mem_rdata;
                m_resp_to = m_who;
                m_busy = 1'b0;
            end
        end else begin
            want_i = i_pmem_read;
            want_d = d_pmem_read || d_pmem_write;
            if (want_i && want_d) who = (m_last == 1) ? 2 : 1;
            else if (want_i) who = 1;
            else if (want_d) who = 2;
            else who = 0;
            if (who == 1) begin
                m_busy = 1'b1; m_who = 1; m_last = 1; m_addr = i_pmem_address; m_wr = 1'b0;
            end else if (who == 2) begin
                m_busy = 1'b1; m_who = 2; m_last = 2; m_addr = d_pmem_address;
                m_wr = d_pmem_write; m_wdata = d_pmem_wdata;
            end
        end
    endtask

    // ---------------- compare process ----------------
    logic [31:0] grant_q[$];
    int i_resp_n = 0;
    int d_resp_n = 0;
    initial begin
        bit prev_strobe;
        bit strobe;
        int gap;
        bit seen_txn;
        prev_strobe = 1'b0;
        gap = 0;
        seen_txn = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("mem_read",     mem_read,     m_busy && !m_wr);
            chk("mem_write",    mem_write,    m_busy && m_wr);
            chk("mem_address",  mem_address,  m_addr);
            chk("mem_wdata",    mem_wdata,    m_wdata);
            chk("i_pmem_resp",  i_pmem_resp,  m_resp_to == 1);
            chk("d_pmem_resp",  d_pmem_resp,  m_resp_to == 2);
            chk("i_pmem_rdata", i_pmem_rdata, m_line);
            chk("d_pmem_rdata", d_pmem_rdata, m_line);
            strobe = mem_read || mem_write;
            if (strobe && !prev_strobe) begin
                grant_q.push_back(mem_address);
                if (seen_txn) chk("turnaround_gap", gap >= 1, 1'b1);
                seen_txn = 1'b1;
            end
            if (strobe) gap = 0;
            else gap++;
            prev_strobe = strobe;
            if (i_pmem_resp) i_resp_n++;
            if (d_pmem_resp) d_resp_n++;
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((i_pmem_read || d_pmem_read || d_pmem_write || mem_read || mem_write ||
                i_pmem_resp || d_pmem_resp || i_left > 0 || d_left > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, n < budget, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int i0;
        int d0;
        rst = 1'b0;
        i_pmem_address = '0; i_pmem_read = 1'b0;
        d_pmem_address = '0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_mem_read",  mem_read,     1'b0);
        chk("rst_mem_write", mem_write,    1'b0);
        chk("rst_mem_addr",  mem_address,  32'h0);
        chk("rst_rdata",     i_pmem_rdata, 256'h0);
        rst = 1'b1;
        @(negedge clk);

        // icache fill, memory answers in the 4th strobe cycle
        mem_lat = 4;
        @(negedge clk);
        i_pmem_address = 32'h0000_1000;
        i_pmem_read = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                chk("t1_read", mem_read, 1'b1);
                chk("t1_addr", mem_address, 32'h0000_1000);
            end else begin
                chk("t1_read_off", mem_read, 1'b0);
            end
            chk("t1_iresp", i_pmem_resp, k == 5);
            chk("t1_dresp", d_pmem_resp, 1'b0);
            if (k == 5) chk("t1_rdata", i_pmem_rdata, LINE_A);
        end

        // dcache writeback
        repeat (2) @(negedge clk);
        mem_lat = 2;
        d_pmem_address = 32'h8000_0040;
        d_pmem_wdata = LINE_B;
        d_pmem_write = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 2) begin
                chk("t2_write", mem_write, 1'b1);
                chk("t2_read",  mem_read,  1'b0);
                chk("t2_wdata", mem_wdata, LINE_B);
                chk("t2_addr",  mem_address, 32'h8000_0040);
            end
            chk("t2_dresp", d_pmem_resp, k == 3);
            chk("t2_iresp", i_pmem_resp, 1'b0);
        end
        chk("t2_line_kept", d_pmem_rdata, LINE_A);

        // simultaneous requests after reset: dcache first
        do_reset();
        grant_q.delete();
        i0 = i_resp_n;
        d0 = d_resp_n;
        mem_lat = 3;
        i_pmem_address = 32'h0000_3000; i_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_2000; d_pmem_read = 1'b1;
        wait_idle(100, "t3");
        chk("t3_ngrant", grant_q.size(), 2);
        if (grant_q.size() == 2) begin
            chk("t3_first",  grant_q[0], 32'h0000_2000);
            chk("t3_second", grant_q[1], 32'h0000_3000);
        end
        chk("t3_iresp_n", i_resp_n - i0, 1);
        chk("t3_dresp_n", d_resp_n - d0, 1);

        // continuous contention: D, I, D, I
        do_reset();
        grant_q.delete();
        mem_lat = 1;
        i_next = 32'h0000_4040; i_left = 1;
        d_next = 32'h0000_5040; d_left = 1;
        i_pmem_address = 32'h0000_4000; i_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_5000; d_pmem_read = 1'b1;
        wait_idle(200, "t4");
        chk("t4_ngrant", grant_q.size(), 4);
        if (grant_q.size() == 4) begin
            chk("t4_g0", grant_q[0], 32'h0000_5000);
            chk("t4_g1", grant_q[1], 32'h0000_4000);
            chk("t4_g2", grant_q[2], 32'h0000_5040);
            chk("t4_g3", grant_q[3], 32'h0000_4040);
        end

        // reset during a writeback; a late mem_resp is ignored
        repeat (2) @(negedge clk);
        d0 = d_resp_n;
        mem_lat = 20;
        d_pmem_address = 32'h0000_6000; d_pmem_wdata = LINE_C; d_pmem_write = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_write_held", mem_write, 1'b1);
        rst = 1'b0;
        d_pmem_write = 1'b0;
        @(negedge clk);
        chk("t5_write_off", mem_write,    1'b0);
        chk("t5_read_off",  mem_read,     1'b0);
        chk("t5_addr_clr",  mem_address,  32'h0);
        chk("t5_wdata_clr", mem_wdata,    256'h0);
        chk("t5_line_clr",  d_pmem_rdata, 256'h0);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #2 stray = 1'b1;
        @(posedge clk); #2 stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_dresp", d_resp_n - d0, 0);
        chk("t5_no_capture", i_pmem_rdata, 256'h0);

        // dcache inputs wander mid-grant; memory side keeps latched values
        mem_lat = 5;
        @(negedge clk);
        d_pmem_address = 32'h0000_7000; d_pmem_wdata = LINE_D; d_pmem_write = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 5) begin
                chk("t6_write", mem_write,   1'b1);
                chk("t6_addr",  mem_address, 32'h0000_7000);
                chk("t6_wdata", mem_wdata,   LINE_D);
            end
            chk("t6_dresp", d_pmem_resp, k == 6);
            if (k == 1 || k == 3) begin
                d_pmem_address = d_pmem_address + 32'h0FC0;
                d_pmem_wdata = ~d_pmem_wdata;
            end
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
